gg_mem_wr_ctrl: RTL

Write-side controller between the byte-align/word-pack stage and the memory write port. It buffers the non-blocking 512-bit packed word stream in a small FIFO and issues valid/ready writes into a ring buffer in memory, generating the 64-byte-granular addresses. It sequences each encode run through start, flush, drain and done, and flags overflow when the upstream stream outpaces memory.

---
 rtl/gg_mem_wr_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gg_mem_wr_ctrl.sv
// rtl/gg_mem_wr_ctrl.sv - packed-word FIFO and ring-buffer write controller (optional stats: GG_MEM_WR_STATS_EN)
module gg_mem_wr_ctrl #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32,
    parameter int FLUSH_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       cfg_base,
    input  logic [ADDR_W-7:0]       cfg_words,
    input  logic                    start,
    input  logic                    flush,
    input  logic [511:0]            in_word,
    input  logic [63:0]             in_startcode,
    input  logic                    in_valid,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [511:0]            wr_data,
    output logic [63:0]             wr_startcode,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
`ifdef GG_MEM_WR_STATS_EN
    ,
    output logic [31:0]             stat_words,
    output logic [31:0]             stat_sc_bytes,
    output logic [$clog2(DEPTH):0]  stat_max_level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int OW = ADDR_W - 6;
    localparam int CW = $clog2(FLUSH_LAT + 1);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [OW-1:0] OFF_ONE  = OW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   base_q;
    logic [OW-1:0]   words_q;
    logic [OW-1:0]   offset;
    logic [OW-1:0]   offset_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [575:0]    mem [DEPTH];

    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            drop;
    logic            start_ok;
    logic            unused_cfg_bits;

    // The ring base is 64-byte aligned, so its low bits never reach the address.
    assign unused_cfg_bits = ^cfg_base[5:0];

    // Input is accepted while running, and during the packer flush tail while the countdown is live.
    assign push_req = in_valid && ((state == S_RUN) || ((state == S_DRAIN) && (cnt != '0)));
    assign pop      = wr_valid && wr_ready;
    assign full     = (level == FULL_LVL);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign start_ok = (state == S_IDLE) && start;

    assign wr_valid = (level != '0);
    assign {wr_startcode, wr_data} = mem[rd_ptr];
    assign wr_addr  = {base_q + offset, 6'b0};

    // Next ring offset: wrap at the configured ring size, or naturally when the size is 0.
    always_comb begin
        offset_next = offset + OFF_ONE;
        if ((words_q != '0) && (offset == words_q - OFF_ONE)) begin
            offset_next = '0;
        end
    end

    // Run sequencing: IDLE -> RUN -> DRAIN (flush tail + empty FIFO) -> DONE pulse -> IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            base_q   <= '0;
            words_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        base_q   <= cfg_base[ADDR_W-1:6];
                        words_q  <= cfg_words;
                        overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_DRAIN;
                        cnt   <= CNT_INIT;
                    end
                end
                S_DRAIN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (level == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and ring offset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            offset <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (start_ok) begin
                offset <= '0;
            end else if (pop) begin
                offset <= offset_next;
            end
        end
    end

    // Word storage; a push while full only happens alongside a pop, so the head is never clobbered early.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_startcode, in_word};
        end
    end

`ifdef GG_MEM_WR_STATS_EN
    function automatic logic [6:0] popcnt64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'b0, v[i]};
        end
        return c;
    endfunction

    logic [32:0] sc_sum;
    assign sc_sum = {1'b0, stat_sc_bytes} + {26'b0, popcnt64(wr_startcode)};

    // Per-run write statistics, saturating, cleared at the start of each run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words     <= '0;
            stat_sc_bytes  <= '0;
            stat_max_level <= '0;
        end else if (start_ok) begin
            stat_words     <= '0;
            stat_sc_bytes  <= '0;
            stat_max_level <= '0;
        end else begin
            if (pop && (stat_words != 32'hFFFF_FFFF)) begin
                stat_words <= stat_words + 32'd1;
            end
            if (pop) begin
                stat_sc_bytes <= sc_sum[32] ? 32'hFFFF_FFFF : sc_sum[31:0];
            end
            if (level > stat_max_level) begin
                stat_max_level <= level;
            end
        end
    end
`endif

endmodule
